num_scan_capture: RTL and testbench
===================================

Name: num_scan_capture

Overview:
Receiving end of the 8-digit multiplexed seven-segment scan interface. It samples the digit-select lines and segment lines, decodes each segment pattern back to a 4-bit value, and rebuilds the 32-bit display word (8 x 4 bits, digit k in bits [4k+3:4k]). It is used for loopback self-check of the display path and for capturing an external scanned display. It sits beside the display driver and feeds the checker/UART logic.

Parameters:
DIGITS, 8, number of scanned digits; the select bus and valid_o are DIGITS wide, data_o is 4*DIGITS wide.
STABLE_CNT, 1, number of consecutive identical registered samples (same select and same segments) required before a digit commits; range 1..15.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
sig_i  in  DIGITS  digit select, active-low, expected one-hot-low
seg_i  in  8  segments, active-high, bit7=a … bit1=g, bit0=dp
data_o  out  4*DIGITS  reconstructed word, digit k at [4k+3:4k]
valid_o  out  DIGITS  digit k has been committed at least once since reset
blank_o  out  DIGITS  last commit of digit k was a blank pattern (all segments off)
frame_o  out  1  one-cycle pulse when every digit has committed since the previous frame_o
err_o  out  1  one-cycle pulse on an illegal select or an undecodable pattern

Behaviour:
- Reset (async, active-high): data_o=0, valid_o=0, blank_o=0, frame_o=0, err_o=0; input regs = all-high select / 0 segments; stability counter=0; seen mask=0. A reset mid-frame discards partial frames.
- Stage 1: sig_i and seg_i are registered every clk with no synchroniser beyond this stage.
- Select decode on the registered value:
  - all bits high -> idle; no commit, no error, stability counter cleared.
  - exactly one bit low -> index k.
  - two or more bits low -> err_o pulse; counter cleared; nothing committed.
- Pattern decode uses bits[7:1] only; dp is ignored.
  - FC→0, 60→1, DA→2, F2→3, 66→4, B6→5, BE→6, E0→7, FE→8, F6→9 (patterns given with dp=0).
  - All-zero → blank; nibble stored as 4'hF and blank_o[k] set.
  - Any other pattern → err_o pulse, no commit.
- Stability:
  - The counter increments while (k, seg) equals the previous registered sample. It resets to 1 on any change.
  - Commit occurs exactly once, when the counter reaches STABLE_CNT.
  - A longer dwell does not re-commit; the next commit requires a change first.
- Latency with STABLE_CNT=1: an input presented before edge E0 is registered at E0, and data_o, valid_o and blank_o update at E1. Each additional stable count adds one cycle.
- Commit of digit k writes data_o[4k+3:4k], sets valid_o[k], writes blank_o[k] (set if blank, cleared otherwise), and sets seen[k].
- Frame:
  - When a commit makes seen all-ones, frame_o pulses in the same cycle that the final data_o update becomes visible, and seen clears.
  - Digit order is irrelevant. Re-committing an already-seen digit does not advance the frame.
- Simultaneous events: error and commit are mutually exclusive per cycle. An error does not clear the seen mask.
- Counter saturates at STABLE_CNT; no wrap.

Optional Feature:
NUM_CAP_HEX_EN
- Defined: additionally decode EE→A, 3E→B, 9C→C, 7A→D, 9E→E, 8E→F as valid digits. blank_o stays 0 for these; a hex F commit is distinguished from blank by blank_o.
- Undefined: those six patterns raise err_o and do not commit.

Decomposition:
- Package num_pkg holds:
  - DIGITS_DEF=8 and NIBBLE_W=4.
  - SEG_0…SEG_9 and SEG_A…SEG_F pattern constants, plus SEG_BLANK.
  - BLANK_CODE=4'hF.
- Sub-module num_seg_decode: purely combinational; seg[7:1] in; nibble, ok and blank out; the hex decode lives behind NUM_CAP_HEX_EN. The stability/commit/frame logic stays in the top module.

Test Plan:
1. Reset mid-operation: drive digit 3=7, then assert rst for 1 cycle → all outputs 0 immediately; no frame_o afterwards until 8 fresh commits.
2. Loopback of the display driver with data 32'h98765432, STABLE_CNT=1 → after 8 scan cycles data_o=32'h98765432, valid_o=8'hFF, exactly one frame_o per 8-cycle sweep, err_o never.
3. Select sig_i=8'b1111_0011 (two low) with seg=FC → err_o pulse, no data change; then sig_i=8'hFF → no err_o, no commit.
4. STABLE_CNT=3: hold sig_i=8'b1111_1110 / seg=60 for 2 cycles, then change → no commit. Hold 5 cycles → single commit data_o[3:0]=1, 3 cycles after the first registered sample.
5. Blank and hex: seg=00 on digit 5 → data_o[23:20]=F, blank_o[5]=1. seg=EE → err_o without NUM_CAP_HEX_EN; data_o[23:20]=A and blank_o[5]=0 with it.
6. Repeated digit: commit digit 0 twice plus digits 1..6 → no frame_o. Then digit 7 → frame_o pulses together with its data_o update.

Source files
------------

// File: rtl/num_pkg.sv
// Shared constants for the seven-segment scan capture block: digit count,
// nibble width, segment patterns (bit7=a .. bit1=g, bit0=dp) and the code
// stored for a blank digit.
package num_pkg;

    localparam int DIGITS_DEF = 8;
    localparam int NIBBLE_W   = 4;

    localparam logic [7:0] SEG_0     = 8'hFC;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hDA;
    localparam logic [7:0] SEG_3     = 8'hF2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hB6;
    localparam logic [7:0] SEG_6     = 8'hBE;
    localparam logic [7:0] SEG_7     = 8'hE0;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_9     = 8'hF6;
    localparam logic [7:0] SEG_A     = 8'hEE;
    localparam logic [7:0] SEG_B     = 8'h3E;
    localparam logic [7:0] SEG_C     = 8'h9C;
    localparam logic [7:0] SEG_D     = 8'h7A;
    localparam logic [7:0] SEG_E     = 8'h9E;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    localparam logic [NIBBLE_W-1:0] BLANK_CODE = 4'hF;

endpackage

// File: rtl/num_scan_capture_if.sv
// Scan-side bundle for num_scan_capture: the display driver (master) drives
// the active-low digit selects and segment lines; the capture block (slave)
// returns the rebuilt word and its status pulses.
interface num_scan_capture_if
    import num_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF
);
    logic [DIGITS-1:0]          sig_i;
    logic [7:0]                 seg_i;
    logic [NIBBLE_W*DIGITS-1:0] data_o;
    logic [DIGITS-1:0]          valid_o;
    logic [DIGITS-1:0]          blank_o;
    logic                       frame_o;
    logic                       err_o;

    modport master (
        output sig_i, seg_i,
        input  data_o, valid_o, blank_o, frame_o, err_o
    );

    modport slave (
        input  sig_i, seg_i,
        output data_o, valid_o, blank_o, frame_o, err_o
    );
endinterface

// File: rtl/num_seg_decode.sv
// Combinational seven-segment pattern decoder. The dp bit never reaches this
// module. Hex digits A..F are only accepted when NUM_CAP_HEX_EN is defined;
// otherwise those patterns come back as not-ok.
module num_seg_decode
    import num_pkg::*;
(
    input  logic [6:0]          i_seg,
    output logic [NIBBLE_W-1:0] o_nibble,
    output logic                o_ok,
    output logic                o_blank
);
    logic [7:0] w_pattern;

    assign w_pattern = {i_seg, 1'b0};

    // Map the segment pattern to its value; unknown patterns leave ok low
    always_comb begin
        o_nibble = '0;
        o_ok     = 1'b1;
        o_blank  = 1'b0;
        case (w_pattern)
            SEG_0:     o_nibble = 4'h0;
            SEG_1:     o_nibble = 4'h1;
            SEG_2:     o_nibble = 4'h2;
            SEG_3:     o_nibble = 4'h3;
            SEG_4:     o_nibble = 4'h4;
            SEG_5:     o_nibble = 4'h5;
            SEG_6:     o_nibble = 4'h6;
            SEG_7:     o_nibble = 4'h7;
            SEG_8:     o_nibble = 4'h8;
            SEG_9:     o_nibble = 4'h9;
`ifdef NUM_CAP_HEX_EN
            SEG_A:     o_nibble = 4'hA;
            SEG_B:     o_nibble = 4'hB;
            SEG_C:     o_nibble = 4'hC;
            SEG_D:     o_nibble = 4'hD;
            SEG_E:     o_nibble = 4'hE;
            SEG_F:     o_nibble = 4'hF;
`endif
            SEG_BLANK: begin
                o_nibble = BLANK_CODE;
                o_blank  = 1'b1;
            end
            default:   o_ok = 1'b0;
        endcase
    end
endmodule

// File: rtl/num_scan_capture.sv
// Receiving end of a multiplexed seven-segment scan. Registers the select
// and segment lines, decodes each digit, waits for STABLE_CNT identical
// samples, then commits the nibble into the rebuilt display word. frame_o
// marks the moment every digit has been refreshed. Hex digit decoding is
// enabled by NUM_CAP_HEX_EN (inside num_seg_decode).
module num_scan_capture
    import num_pkg::*;
#(
    parameter int DIGITS     = DIGITS_DEF,
    parameter int STABLE_CNT = 1
)(
    input  logic               clk,
    input  logic               rst,
    num_scan_capture_if.slave  io_scan
);
    localparam int CNT_W = 4;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] STABLE_LIM = CNT_W'(STABLE_CNT);

    logic [DIGITS-1:0]          r_sig;
    logic [7:0]                 r_seg;
    logic [CNT_W-1:0]           r_cnt;
    logic [IDX_W-1:0]           r_prevIdx;
    logic [7:0]                 r_prevSeg;
    logic [DIGITS-1:0]          r_seen;
    logic [NIBBLE_W*DIGITS-1:0] r_data;
    logic [DIGITS-1:0]          r_valid;
    logic [DIGITS-1:0]          r_blank;
    logic                       r_frame;
    logic                       r_err;

    logic [15:0]                w_lowCnt;
    logic [IDX_W-1:0]           w_idx;
    logic                       w_oneLow;
    logic                       w_multiLow;
    logic [NIBBLE_W-1:0]        w_nibble;
    logic                       w_decOk;
    logic                       w_decBlank;
    logic                       w_same;
    logic [CNT_W-1:0]           w_nextCnt;
    logic                       w_commit;
    logic                       w_err;
    logic [DIGITS-1:0]          w_seenNext;
    logic                       w_frameHit;

    // Single input register stage; idle select (all high) out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig <= '1;
            r_seg <= '0;
        end else begin
            r_sig <= io_scan.sig_i;
            r_seg <= io_scan.seg_i;
        end
    end

    // Count active-low selects and remember which one is low
    always_comb begin
        w_lowCnt = '0;
        w_idx    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!r_sig[i]) begin
                w_lowCnt = w_lowCnt + 16'd1;
                w_idx    = i[IDX_W-1:0];
            end
        end
    end

    assign w_oneLow   = (w_lowCnt == 16'd1);
    assign w_multiLow = (w_lowCnt > 16'd1);

    num_seg_decode u_decode (
        .i_seg    (r_seg[7:1]),
        .o_nibble (w_nibble),
        .o_ok     (w_decOk),
        .o_blank  (w_decBlank)
    );

    assign w_same = (r_cnt != '0) && (w_idx == r_prevIdx) && (r_seg == r_prevSeg);

    // Stability count: restart at 1 on any change, saturate at the limit
    always_comb begin
        w_nextCnt = '0;
        if (w_oneLow) begin
            if (!w_same) begin
                w_nextCnt = CNT_W'(1);
            end else if (r_cnt == STABLE_LIM) begin
                w_nextCnt = r_cnt;
            end else begin
                w_nextCnt = r_cnt + CNT_W'(1);
            end
        end
    end

    assign w_commit   = w_oneLow && w_decOk && (w_nextCnt == STABLE_LIM) &&
                        !(w_same && (r_cnt == STABLE_LIM));
    assign w_err      = w_multiLow || (w_oneLow && !w_decOk);
    assign w_seenNext = r_seen | (DIGITS'(1) << w_idx);
    assign w_frameHit = w_commit && (&w_seenNext);

    // Track the previous registered sample and its stability count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_prevIdx <= '0;
            r_prevSeg <= '0;
        end else begin
            r_cnt <= w_nextCnt;
            if (w_oneLow) begin
                r_prevIdx <= w_idx;
                r_prevSeg <= r_seg;
            end
        end
    end

    // Commit digits into the word, and close a frame once all have been seen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= '0;
            r_blank <= '0;
            r_seen  <= '0;
            r_frame <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_frame <= 1'b0;
            r_err   <= w_err;
            if (w_commit) begin
                r_data[w_idx*NIBBLE_W +: NIBBLE_W] <= w_nibble;
                r_valid[w_idx] <= 1'b1;
                r_blank[w_idx] <= w_decBlank;
                if (w_frameHit) begin
                    r_seen  <= '0;
                    r_frame <= 1'b1;
                end else begin
                    r_seen  <= w_seenNext;
                end
            end
        end
    end

    assign io_scan.data_o  = r_data;
    assign io_scan.valid_o = r_valid;
    assign io_scan.blank_o = r_blank;
    assign io_scan.frame_o = r_frame;
    assign io_scan.err_o   = r_err;
endmodule

// File: tb/tb_num_scan_capture.sv
// Directed bench for num_scan_capture: one instance with STABLE_CNT=1 for
// loopback, reset, error, blank/hex and frame behaviour, and one with
// STABLE_CNT=3 for the dwell filter. Hex results depend on NUM_CAP_HEX_EN.
module tb_num_scan_capture;
    import num_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks   = 0;
    int failures = 0;
    int frames;
    int errs;

    logic [7:0] segTab [10] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4,
                                SEG_5, SEG_6, SEG_7, SEG_8, SEG_9};

    num_scan_capture_if #(.DIGITS(8)) scan1 ();
    num_scan_capture_if #(.DIGITS(8)) scan3 ();

    num_scan_capture #(.DIGITS(8), .STABLE_CNT(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .io_scan (scan1)
    );

    num_scan_capture #(.DIGITS(8), .STABLE_CNT(3)) dut3 (
        .clk     (clk),
        .rst     (rst),
        .io_scan (scan3)
    );

    // Free-running 10-time-unit clock
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int dig, input logic [7:0] seg);
        scan1.sig_i = ~(8'd1 << dig);
        scan1.seg_i = seg;
    endtask

    task automatic applyIdle;
        scan1.sig_i = 8'hFF;
        scan1.seg_i = 8'h00;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one digit per cycle for a full sweep, counting frame/err pulses
    task automatic sweepWord(input logic [31:0] word, output int nFrames, output int nErrs);
        logic [3:0] v;
        nFrames = 0;
        nErrs   = 0;
        for (int k = 0; k < 8; k++) begin
            v = word[4*k +: 4];
            applyStimulus(k, segTab[v]);
            tick;
            if (scan1.frame_o) nFrames++;
            if (scan1.err_o)   nErrs++;
        end
        applyIdle;
        tick;
        if (scan1.frame_o) nFrames++;
        if (scan1.err_o)   nErrs++;
    endtask

    // Directed sequence
    initial begin
        applyIdle;
        scan3.sig_i = 8'hFF;
        scan3.seg_i = 8'h00;
        #1 rst = 1'b1;
        #1;
        checkOutput("rstData",  scan1.data_o,  32'h0);
        checkOutput("rstValid", {24'h0, scan1.valid_o}, 32'h0);
        checkOutput("rstBlank", {24'h0, scan1.blank_o}, 32'h0);
        checkOutput("rstFrame", {31'h0, scan1.frame_o}, 32'h0);
        checkOutput("rstErr",   {31'h0, scan1.err_o},   32'h0);
        tick;
        rst = 1'b0;

        // Commit one digit, then reset mid-frame
        applyStimulus(3, SEG_7);
        tick;
        applyIdle;
        tick;
        checkOutput("d3Data",  scan1.data_o, 32'h0000_7000);
        checkOutput("d3Valid", {24'h0, scan1.valid_o}, 32'h08);
        rst = 1'b1;
        #1;
        checkOutput("midRstData",  scan1.data_o, 32'h0);
        checkOutput("midRstValid", {24'h0, scan1.valid_o}, 32'h0);
        tick;
        rst = 1'b0;

        // Seven fresh commits without digit 3 must not close a frame
        frames = 0;
        for (int d = 0; d < 8; d++) begin
            if (d != 3) begin
                applyStimulus(d, segTab[d]);
                tick;
                if (scan1.frame_o) frames++;
            end
        end
        applyIdle;
        tick;
        if (scan1.frame_o) frames++;
        checkOutput("noFrameAfterRst", frames, 0);
        applyStimulus(3, SEG_3);
        tick;
        applyIdle;
        tick;
        checkOutput("frameD3",     {31'h0, scan1.frame_o}, 32'h1);
        checkOutput("frameD3Data", scan1.data_o, 32'h7654_3210);
        checkOutput("frameD3Val",  {24'h0, scan1.valid_o}, 32'hFF);

        // Loopback sweeps
        sweepWord(32'h9876_5432, frames, errs);
        checkOutput("sweep1Frames", frames, 1);
        checkOutput("sweep1Errs",   errs, 0);
        checkOutput("sweep1Data",   scan1.data_o, 32'h9876_5432);
        checkOutput("sweep1Valid",  {24'h0, scan1.valid_o}, 32'hFF);
        sweepWord(32'h0123_4567, frames, errs);
        checkOutput("sweep2Frames", frames, 1);
        checkOutput("sweep2Errs",   errs, 0);
        checkOutput("sweep2Data",   scan1.data_o, 32'h0123_4567);

        // Two selects low for one cycle
        scan1.sig_i = 8'b1111_0011;
        scan1.seg_i = SEG_0;
        tick;
        applyIdle;
        tick;
        checkOutput("multiSelErr",  {31'h0, scan1.err_o}, 32'h1);
        checkOutput("multiSelData", scan1.data_o, 32'h0123_4567);
        tick;
        checkOutput("idleErr",  {31'h0, scan1.err_o}, 32'h0);
        checkOutput("idleData", scan1.data_o, 32'h0123_4567);

        // Undecodable pattern (segment g only)
        applyStimulus(2, 8'h02);
        tick;
        applyIdle;
        tick;
        checkOutput("badPatErr",  {31'h0, scan1.err_o}, 32'h1);
        checkOutput("badPatData", scan1.data_o, 32'h0123_4567);

        // Blank on digit 5
        applyStimulus(5, SEG_BLANK);
        tick;
        applyIdle;
        tick;
        checkOutput("blankNib", {28'h0, scan1.data_o[23:20]}, 32'hF);
        checkOutput("blankBit", {24'h0, scan1.blank_o}, 32'h20);

        // Hex A on digit 5
        applyStimulus(5, SEG_A);
        tick;
        applyIdle;
        tick;
`ifdef NUM_CAP_HEX_EN
        checkOutput("hexErr",   {31'h0, scan1.err_o}, 32'h0);
        checkOutput("hexNib",   {28'h0, scan1.data_o[23:20]}, 32'hA);
        checkOutput("hexBlank", {24'h0, scan1.blank_o}, 32'h00);
`else
        checkOutput("hexErr",   {31'h0, scan1.err_o}, 32'h1);
        checkOutput("hexNib",   {28'h0, scan1.data_o[23:20]}, 32'hF);
        checkOutput("hexBlank", {24'h0, scan1.blank_o}, 32'h20);
`endif

        // Decimal point is ignored by the decoder
        applyStimulus(2, SEG_1 | 8'h01);
        tick;
        applyIdle;
        tick;
        checkOutput("dpNib", {28'h0, scan1.data_o[11:8]}, 32'h1);
        checkOutput("dpErr", {31'h0, scan1.err_o}, 32'h0);

        // Repeated digit 0 and an error mid-frame must not close the frame
        rst = 1'b1;
        tick;
        rst = 1'b0;
        frames = 0;
        errs   = 0;
        applyStimulus(0, SEG_5); tick; if (scan1.frame_o) frames++; if (scan1.err_o) errs++;
        applyStimulus(0, SEG_6); tick; if (scan1.frame_o) frames++; if (scan1.err_o) errs++;
        for (int d = 1; d < 7; d++) begin
            applyStimulus(d, segTab[d]);
            tick;
            if (scan1.frame_o) frames++;
            if (scan1.err_o)   errs++;
            if (d == 3) begin
                scan1.sig_i = 8'b0011_1111;
                scan1.seg_i = SEG_8;
                tick;
                if (scan1.frame_o) frames++;
                if (scan1.err_o)   errs++;
            end
        end
        applyIdle;
        tick;
        if (scan1.frame_o) frames++;
        if (scan1.err_o)   errs++;
        tick;
        if (scan1.err_o)   errs++;
        checkOutput("repeatNoFrame", frames, 0);
        checkOutput("repeatErrCnt",  errs, 1);
        applyStimulus(7, SEG_9);
        tick;
        applyIdle;
        tick;
        checkOutput("d7Frame", {31'h0, scan1.frame_o}, 32'h1);
        checkOutput("d7Data",  scan1.data_o, 32'h9654_3216);
        tick;
        checkOutput("d7FrameOnce", {31'h0, scan1.frame_o}, 32'h0);

        // Dwell filter with STABLE_CNT=3: two samples do not commit
        scan3.sig_i = 8'b1111_1110;
        scan3.seg_i = SEG_1;
        tick;
        tick;
        scan3.sig_i = 8'hFF;
        scan3.seg_i = 8'h00;
        tick;
        tick;
        tick;
        checkOutput("s3ShortValid", {24'h0, scan3.valid_o}, 32'h0);
        checkOutput("s3ShortData",  scan3.data_o, 32'h0);

        // Five-cycle hold commits on the third registered sample
        scan3.sig_i = 8'b1111_1110;
        scan3.seg_i = SEG_1;
        tick;
        tick;
        tick;
        checkOutput("s3TwoValid", {24'h0, scan3.valid_o}, 32'h0);
        tick;
        checkOutput("s3CommitValid", {24'h0, scan3.valid_o}, 32'h01);
        checkOutput("s3CommitData",  scan3.data_o, 32'h1);
        tick;
        scan3.seg_i = SEG_2;
        tick;
        tick;
        scan3.sig_i = 8'hFF;
        scan3.seg_i = 8'h00;
        tick;
        tick;
        tick;
        checkOutput("s3ShortChange", scan3.data_o, 32'h1);
        checkOutput("s3Err", {31'h0, scan3.err_o}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
